// File: rtl/framebuffer_arbiter.sv
// Framebuffer SDRAM arbiter: shares one SDRAM port between the scanout
// reader and the pixel generator. The reader fills the scanout FIFO in
// fixed uninterruptible bursts. The writer streams generator words in
// bounded bursts into the back buffer. Reads always win over writes.
//
// Handshakes:
//   wr_valid/wr_ready : wr_data is consumed on the clock edge that ends a
//                       cycle in which both are 1. wr_ready may depend on
//                       wr_valid in the same cycle, and is never 1 unless
//                       a word is taken.
//   data_read_valid   : one read word per cycle in READ. It is forwarded to
//                       the FIFO combinationally.
//   data_write_done   : the SDRAM accepted data_write in WRITE this cycle.
//
// The FSM state is visible on command, which equals the state encoding.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH         = 22,
  parameter int DATA_WIDTH         = 32,
  parameter int READ_BURST_LENGTH  = 8,
  parameter int WRITE_BURST_LENGTH = 8,
  parameter int FRAME_WORDS        = 96000,
  parameter int BUFFER1_BASE       = 96000,
  parameter int DOUBLE_BUFFER      = 1,
  parameter int FIFO_DEPTH         = 1024,
  parameter int USED_WIDTH         = 10,
  parameter int LOW_THRESHOLD      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_read_valid,
  input  logic                  data_write_done,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_en,
  input  logic [USED_WIDTH-1:0] fifo_wrusedw,
  output logic                  first_data_ready,
  output logic                  front_buffer,
  output logic                  frame_written
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam int RCW = $clog2(READ_BURST_LENGTH + 1);
  localparam int WCW = $clog2(WRITE_BURST_LENGTH + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE1       = ADDR_WIDTH'(BUFFER1_BASE);
  localparam logic [USED_WIDTH-1:0] LOW_LEVEL   = USED_WIDTH'(LOW_THRESHOLD);
  localparam logic [USED_WIDTH-1:0] HIGH_LEVEL  = USED_WIDTH'(FIFO_DEPTH - READ_BURST_LENGTH);
  localparam logic [RCW-1:0]        READ_LAST   = RCW'(READ_BURST_LENGTH - 1);
  localparam logic [WCW-1:0]        WRITE_LAST  = WCW'(WRITE_BURST_LENGTH - 1);
  localparam logic                  DOUBLE      = (DOUBLE_BUFFER != 0);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_offset;
  logic [ADDR_WIDTH-1:0] wr_offset;
  logic [RCW-1:0]        rd_count;
  logic [WCW-1:0]        wr_count;
  logic                  fill;
  logic                  fill_next;
  logic                  swap_pending;
  logic                  stalled;
  logic                  rd_word;
  logic                  wr_word;
  logic                  rd_wrap;
  logic                  wr_wrap;
  logic                  rd_burst_end;
  logic                  wr_burst_end;
  logic                  start_read;
  logic                  start_write;
  logic                  take_word;
  logic [ADDR_WIDTH-1:0] read_base;
  logic [ADDR_WIDTH-1:0] write_base;

  // Fill hysteresis and the transfer events of the current cycle.
  always_comb begin
    fill_next = fill;
    if (fifo_wrusedw <= LOW_LEVEL) fill_next = 1'b1;
    if (fifo_wrusedw >= HIGH_LEVEL) fill_next = 1'b0;
    stalled      = DOUBLE && swap_pending;
    rd_word      = (state == ST_READ) && data_read_valid;
    wr_word      = (state == ST_WRITE) && data_write_done;
    rd_wrap      = (rd_offset == LAST_OFFSET);
    wr_wrap      = (wr_offset == LAST_OFFSET);
    rd_burst_end = rd_word && (rd_count == READ_LAST);
    wr_burst_end = wr_word && ((wr_count == WRITE_LAST) || !wr_valid || wr_wrap);
    start_read   = (state == ST_IDLE) && fill_next;
    start_write  = (state == ST_IDLE) && !fill_next && wr_valid && !stalled;
    take_word    = !reset && (start_write || (wr_word && !wr_burst_end));
  end

  // Address generation: reads from the front buffer, writes to the other one.
  always_comb begin
    read_base    = front_buffer ? BASE1 : '0;
    write_base   = (DOUBLE && !front_buffer) ? BASE1 : '0;
    data_address = read_base + rd_offset;
    if (state == ST_WRITE) data_address = write_base + wr_offset;
    if (reset) data_address = '0;
  end

  assign command      = state;
  assign wr_ready     = take_word;
  assign fifo_wr_en   = !reset && rd_word;
  assign fifo_wr_data = data_read;

  // Arbitration FSM with burst word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_read) begin
            state    <= ST_READ;
            rd_count <= '0;
          end else if (start_write) begin
            state    <= ST_WRITE;
            wr_count <= '0;
          end
        end
        ST_READ: begin
          if (rd_word) begin
            rd_count <= rd_count + RCW'(1);
            if (rd_burst_end) state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (wr_word) begin
            wr_count <= wr_count + WCW'(1);
            if (wr_burst_end) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame offsets, wrapping at the end of the frame even mid-burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_offset <= '0;
      wr_offset <= '0;
    end else begin
      if (rd_word) rd_offset <= rd_wrap ? '0 : rd_offset + ADDR_WIDTH'(1);
      if (wr_word) wr_offset <= wr_wrap ? '0 : wr_offset + ADDR_WIDTH'(1);
    end
  end

  // Buffer swap: a finished frame waits until scanout wraps before flipping.
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_pending     <= 1'b0;
      front_buffer     <= 1'b0;
      frame_written    <= 1'b0;
      first_data_ready <= 1'b0;
      fill             <= 1'b0;
    end else begin
      fill          <= fill_next;
      frame_written <= wr_word && wr_wrap;
      if (rd_burst_end) first_data_ready <= 1'b1;
      if (wr_word && wr_wrap && DOUBLE) swap_pending <= 1'b1;
      if (rd_word && rd_wrap && swap_pending) begin
        front_buffer <= ~front_buffer;
        swap_pending <= 1'b0;
      end
    end
  end

  // Write data register, loaded whenever a generator word is accepted.
  always_ff @(posedge clk) begin
    if (reset) data_write <= '0;
    else if (take_word) data_write <= wr_data;
  end

endmodule
